// File: rtl/gpio_input_port_if.sv
// Core-side bus and pin bundle for the GPIO input peripheral.
// The core drives the bus as master; the peripheral is the slave.
interface gpio_input_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int GPIO_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] Address_i;
    logic                  Read_Enable_i;
    logic                  Write_Enable_i;
    logic [DATA_WIDTH-1:0] Write_Data_i;
    logic [GPIO_WIDTH-1:0] GPIO_i;
    logic [DATA_WIDTH-1:0] Read_Data_o;
    logic                  Select_o;
    logic                  Irq_o;

    modport master (
        output Address_i, Read_Enable_i, Write_Enable_i, Write_Data_i,
        input  Read_Data_o, Select_o, Irq_o
    );

    modport slave (
        input  Address_i, Read_Enable_i, Write_Enable_i, Write_Data_i,
        input  GPIO_i,
        output Read_Data_o, Select_o, Irq_o
    );
endinterface

// File: rtl/gpio_input_port.sv
// Memory-mapped GPIO input port: synchronizer, debounce,
// sticky clear-on-read rising-edge flags, mask and interrupt.
module gpio_input_port #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          GPIO_WIDTH      = 8,
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0024,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input logic         clk,
    input logic         reset,
    gpio_input_port_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [DATA_WIDTH-1:0] ADDR_DATA = DATA_WIDTH'(BASE_ADDR);
    localparam logic [DATA_WIDTH-1:0] ADDR_EDGE = DATA_WIDTH'(BASE_ADDR + 32'd4);
    localparam logic [DATA_WIDTH-1:0] ADDR_MASK = DATA_WIDTH'(BASE_ADDR + 32'd8);

    logic [GPIO_WIDTH-1:0] sync1;
    logic [GPIO_WIDTH-1:0] sync2;
    logic [GPIO_WIDTH-1:0] stable;
    logic [GPIO_WIDTH-1:0] edge_q;
    logic [GPIO_WIDTH-1:0] mask_q;
    logic [GPIO_WIDTH-1:0] accept;
    logic [GPIO_WIDTH-1:0] rise;
    logic [CW-1:0]         cnt [GPIO_WIDTH];
    logic                  irq_q;
    logic                  hit_data;
    logic                  hit_edge;
    logic                  hit_mask;
    logic                  clr_edge;
    logic                  ld_mask;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  unused_wdata;

    assign hit_data = (bus.Address_i == ADDR_DATA);
    assign hit_edge = (bus.Address_i == ADDR_EDGE);
    assign hit_mask = (bus.Address_i == ADDR_MASK);

    assign bus.Select_o = hit_data | hit_edge | hit_mask;
    assign clr_edge     = bus.Read_Enable_i & hit_edge;
    assign ld_mask      = bus.Write_Enable_i & hit_mask;
    assign unused_wdata = ^bus.Write_Data_i;

    // A bit is accepted once it has differed for DEBOUNCE_CYCLES edges
    always_comb begin
        accept = '0;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    assign rise = accept & sync2 & ~stable;

    // Two-flop synchronizer on the asynchronous pins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.GPIO_i;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce counter and accepted stable level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    cnt[i]    <= '0;
                    stable[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Sticky rising-edge flags; a new edge beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_q <= '0;
        end else begin
            edge_q <= (edge_q & ~{GPIO_WIDTH{clr_edge}}) | rise;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else if (ld_mask) begin
            mask_q <= bus.Write_Data_i[GPIO_WIDTH-1:0];
        end
    end

    // Registered interrupt from pending unmasked edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(edge_q & mask_q);
        end
    end

    // Combinational read mux, zero when nothing is selected
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            hit_data: rdata[GPIO_WIDTH-1:0] = stable;
            hit_edge: rdata[GPIO_WIDTH-1:0] = edge_q;
            hit_mask: rdata[GPIO_WIDTH-1:0] = mask_q;
            default:  rdata = '0;
        endcase
    end

    assign bus.Read_Data_o = rdata;
    assign bus.Irq_o       = irq_q;
endmodule

// File: doc/gpio_input_port.md
Name: gpio_input_port

Overview:
Memory-mapped input peripheral that the multicycle RISC-V core reads through the data-memory address space. It is the input-direction counterpart of the GPIO output path. It synchronizes and debounces external pins, and latches rising edges in sticky flags that are cleared when read. It exposes a level register, an edge register and a mask register, and raises an interrupt request.

Parameters:
DATA_WIDTH, 32, bus data/address width
GPIO_WIDTH, 8, number of input pins (1..32)
BASE_ADDR, 32'h10010024, byte address of DATA register; EDGE at +4, MASK at +8
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a new pin level (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Address_i  input  DATA_WIDTH  byte address from core
Read_Enable_i  input  1  core read strobe, one cycle per access
Write_Enable_i  input  1  core write strobe
Write_Data_i  input  DATA_WIDTH  write data from core
GPIO_i  input  GPIO_WIDTH  asynchronous external pins
Read_Data_o  output  DATA_WIDTH  register read data, zero-extended
Select_o  output  1  high when Address_i hits one of the three registers
Irq_o  output  1  interrupt request

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchronizer flops, stable level, debounce counters, EDGE and MASK all clear to 0.
  - Read_Data_o=0, Irq_o=0.
  - Select_o is combinational from Address_i and is unaffected by reset.
- Synchronizer: two flops per bit. sync = GPIO_i delayed 2 cycles.
- Debounce, per bit:
  - Each bit has a counter of width clog2(DEBOUNCE_CYCLES)+1.
  - If sync != stable, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable takes sync on that edge and the counter returns to 0.
  - If sync == stable, the counter is 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - Pin-to-stable latency is 2+DEBOUNCE_CYCLES cycles.
- Edge capture:
  - EDGE[i] is set on the cycle stable[i] goes 0->1, irrespective of MASK.
  - Falling edges are ignored.
- Address decode:
  - Select_o=1 for Address_i equal to BASE_ADDR, BASE_ADDR+4 or BASE_ADDR+8 exactly.
  - Addresses that are in range but not word-aligned do not select.
- Read path:
  - Read_Data_o is combinational and is 0 when Select_o=0.
  - DATA returns stable, EDGE returns EDGE, MASK returns MASK; all are zero-extended to 32 bits.
  - The value returned is the pre-clock value, so the core samples it in the same cycle it asserts Read_Enable_i.
- Clear-on-read:
  - On a clock edge with Read_Enable_i=1 and Address_i=BASE_ADDR+4, EDGE clears to 0.
  - If a new rising edge occurs on the same cycle, set wins for that bit and the bit is 1 afterwards.
  - Reads of DATA and MASK have no side effects.
- Write path:
  - Write_Enable_i=1 and Address_i=BASE_ADDR+8 loads MASK with Write_Data_i[GPIO_WIDTH-1:0].
  - Writes to DATA and EDGE are ignored.
- Simultaneous strobes:
  - Read_Enable_i and Write_Enable_i together is illegal from the core.
  - If it occurs, both actions are performed independently.
- Interrupt: Irq_o = |(EDGE & MASK), registered, so it asserts 1 cycle after the EDGE/MASK update.
- Non-selected accesses leave all state unchanged.

Test Plan:
1. Reset then idle with GPIO_i=8'h00 -> Read_Data_o=0 at BASE_ADDR, +4 and +8; Irq_o=0; Select_o=0 at 0x10010000 and 1 at 0x10010024.
2. GPIO_i 8'h00->8'h05 held, DEBOUNCE_CYCLES=4 -> DATA reads 8'h00 for 5 cycles and 8'h05 from cycle 6; EDGE reads 8'h05.
3. 3-cycle pulse on GPIO_i[2] -> DATA and EDGE remain 0. A 6-cycle pulse then sets EDGE[2]=1; the falling edge leaves EDGE unchanged.
4. Write MASK=8'h04, then a rising edge on bit 2 -> Irq_o=1 one cycle after EDGE[2] sets. Read of +4 returns 8'h04, EDGE becomes 0 next cycle, and Irq_o drops the cycle after.
5. Force a rising edge on bit 0 in the same cycle as an EDGE read -> Read_Data_o shows the old value and EDGE[0]=1 afterwards.
6. Assert reset mid-debounce with GPIO_i=8'hFF for 3 cycles -> all outputs 0 immediately (asynchronous). After release, DATA becomes 8'hFF 2+4 cycles later.
